// File: rtl/scan_select_if.sv
// Handshake and select bundle between the scan sequencer and its
// controller / downstream 3-to-8 decoder.
interface scan_select_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               valid;
  logic               busy;
  logic               step;
  logic               done;

  modport master (
    output start, stop, continuous, mask, dwell,
    input  sel, valid, busy, step, done
  );

  modport slave (
    input  start, stop, continuous, mask, dwell,
    output sel, valid, busy, step, done
  );
endinterface

// File: rtl/scan_select_sequencer.sv
// Steps a 3-bit select code through enabled lines of an 8-bit mask,
// holding each line dwell+1 cycles, single-sweep or continuous.
module scan_select_sequencer #(
  parameter int DWELL_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  scan_select_if.slave bus
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t             state, state_n;
  logic [2:0]         sel_q, sel_n;
  logic               valid_q, valid_n;
  logic               busy_q, busy_n;
  logic               step_q, step_n;
  logic               done_q, done_n;
  logic [7:0]         sh_mask, sh_mask_n;
  logic [DWELL_W-1:0] sh_dwell, sh_dwell_n;
  logic               sh_cont, sh_cont_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [7:0]         above;

  function automatic logic [2:0] low_idx(
    input logic [7:0] m
  );
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) low_idx = i[2:0];
  endfunction

  // enabled lines strictly above the current one
  assign above = sh_mask & (8'hFE << sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      sh_mask  <= '0;
      sh_dwell <= '0;
      sh_cont  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      sel_q    <= sel_n;
      valid_q  <= valid_n;
      busy_q   <= busy_n;
      step_q   <= step_n;
      done_q   <= done_n;
      sh_mask  <= sh_mask_n;
      sh_dwell <= sh_dwell_n;
      sh_cont  <= sh_cont_n;
      cnt      <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel_q;
    valid_n    = valid_q;
    busy_n     = busy_q;
    step_n     = 1'b0;
    done_n     = 1'b0;
    sh_mask_n  = sh_mask;
    sh_dwell_n = sh_dwell;
    sh_cont_n  = sh_cont;
    cnt_n      = cnt;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (bus.start && bus.mask != 8'd0) begin
          sh_mask_n  = bus.mask;
          sh_dwell_n = bus.dwell;
          sh_cont_n  = bus.continuous;
          sel_n      = low_idx(bus.mask);
          cnt_n      = bus.dwell;
          valid_n    = 1'b1;
          busy_n     = 1'b1;
          state_n    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.stop) begin
          state_n = IDLE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (above != 8'd0) begin
          sel_n  = low_idx(above);
          cnt_n  = sh_dwell;
          step_n = 1'b1;
        end else if (sh_cont) begin
          sel_n  = low_idx(sh_mask);
          cnt_n  = sh_dwell;
          step_n = 1'b1;
        end else begin
          state_n = IDLE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.step  = step_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Directed and random checks of scan_select_sequencer against a
// line-list reference model.
module tb_scan_select_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_select_if #(.DWELL_W(8)) bus();

  scan_select_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit         m_act;
  int         lines[$];
  int         m_pos, m_hold, m_left;
  bit         m_cont;
  logic [2:0] m_sel;
  logic       m_step, m_done;
  int         busy_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act  = 0;
    m_sel  = 3'd0;
    m_step = 0;
    m_done = 0;
    lines.delete();
  endtask

  task automatic model(bit st, bit sp, bit cn, logic [7:0] mk, int dw);
    m_step = 0;
    m_done = 0;
    if (!m_act) begin
      if (st && mk != 8'd0) begin
        lines.delete();
        for (int i = 0; i < 8; i++)
          if (mk[i]) lines.push_back(i);
        m_pos  = 0;
        m_hold = dw + 1;
        m_left = m_hold;
        m_cont = cn;
        m_sel  = 3'(lines[0]);
        m_act  = 1;
      end
    end else if (sp) begin
      m_act  = 0;
      m_done = 1;
    end else if (m_left > 1) begin
      m_left--;
    end else if (m_pos + 1 < lines.size()) begin
      m_pos++;
      m_sel  = 3'(lines[m_pos]);
      m_left = m_hold;
      m_step = 1;
    end else if (m_cont) begin
      m_pos  = 0;
      m_sel  = 3'(lines[0]);
      m_left = m_hold;
      m_step = 1;
    end else begin
      m_act  = 0;
      m_done = 1;
    end
  endtask

  task automatic check_all();
    chk("sel", 32'(bus.sel), 32'(m_sel));
    chk("valid", 32'(bus.valid), 32'(m_act));
    chk("busy", 32'(bus.busy), 32'(m_act));
    chk("step", 32'(bus.step), 32'(m_step));
    chk("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic cyc(bit st, bit sp, bit cn, logic [7:0] mk, int dw);
    @(negedge clk);
    bus.start      = st;
    bus.stop       = sp;
    bus.continuous = cn;
    bus.mask       = mk;
    bus.dwell      = 8'(dw);
    @(posedge clk);
    model(st, sp, cn, mk, dw);
    #1;
    check_all();
    if (bus.busy) busy_cnt++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    bus.start      = 0;
    bus.stop       = 0;
    bus.continuous = 0;
    bus.mask       = '0;
    bus.dwell      = '0;
    busy_cnt       = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // empty mask start is ignored
    cyc(1, 0, 0, 8'h00, 0);
    idle(2);

    // full single sweep
    cyc(1, 0, 0, 8'hFF, 0);
    idle(9);

    // gapped mask with dwell 2
    busy_cnt = 0;
    cyc(1, 0, 0, 8'b1010_0100, 2);
    idle(10);
    chk("gap_busy_cycles", 32'(busy_cnt), 32'd9);

    // continuous wrap, input mask wiggles mid-scan
    cyc(1, 0, 1, 8'b1000_0001, 1);
    for (int i = 0; i < 7; i++)
      cyc(0, 0, 0, 8'($urandom), 3);
    cyc(0, 1, 0, 8'h00, 0);
    idle(2);

    // stop on expiry cycle, start in ACTIVE ignored
    cyc(1, 0, 1, 8'hFF, 0);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h0F, 3);
    cyc(0, 1, 0, 8'h00, 0);
    idle(2);

    // start and stop together in IDLE: start wins
    cyc(1, 1, 0, 8'h06, 0);
    idle(3);

    // async reset while sel=5
    cyc(1, 0, 0, 8'hF0, 0);
    idle(1);
    chk("pre_reset_sel", 32'(bus.sel), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 8'hF0, 0);
    idle(5);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) == 0, ($urandom % 16) == 0,
          1'($urandom), 8'($urandom), int'($urandom % 4));
    cyc(0, 1, 0, 8'h00, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
